// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
//
// Write-only bus sequencer for an HD44780-compatible 16x2 character LCD.
// Each byte (command or character) is accepted over a valid/ready handshake
// and driven onto the LCD pins with the required timing: address/data setup,
// enable pulse, hold, and the controller's execution wait. Software never
// toggles the enable line itself.
//
// Optional feature (compile-time macro LCD_INIT_EN):
//   When defined, the block waits PWRUP_CYC cycles after reset and then
//   issues the power-on init sequence 0x38, 0x0C, 0x01, 0x06 (rs=0) on its
//   own; ready_o stays low until the final execution wait has elapsed.
//   When undefined, ready_o is high from reset and PWRUP_CYC is unused.
//
// Parameters:
//   SETUP_CYC     cycles RS/data are stable before EN rises   (>=1)
//   EN_CYC        cycles EN is held high                      (>=1)
//   HOLD_CYC      cycles RS/data are held after EN falls      (>=1)
//   CMD_WAIT_CYC  execution wait, normal commands/characters  (>=1)
//   CLR_WAIT_CYC  execution wait, clear/home commands         (>=1)
//   PWRUP_CYC     power-on delay before init (LCD_INIT_EN only)
//   CNT_W         wait-counter width; every *_CYC < 2**CNT_W
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   req_i       request valid
//   ready_o     idle and able to accept a request
//   rs_i        register select for the request (0 command, 1 data)
//   data_i      byte for the request
//   on_i        LCD power/backlight enable request
//   lcd_data_o  LCD data bus
//   lcd_rs_o    LCD register select
//   lcd_rw_o    LCD read/write, tied to 0 (write only)
//   lcd_en_o    LCD enable strobe
//   lcd_on_o    LCD power enable (registered copy of on_i)
// -----------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  output logic       ready_o,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       on_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  // Reject configurations whose timing values do not fit the counter or
  // would give a zero-length phase.
  if ((SETUP_CYC == 0) || (EN_CYC == 0) || (HOLD_CYC == 0) ||
      (CMD_WAIT_CYC == 0) || (CLR_WAIT_CYC == 0) ||
      ((SETUP_CYC    >> CNT_W) != 0) || ((EN_CYC       >> CNT_W) != 0) ||
      ((HOLD_CYC     >> CNT_W) != 0) || ((CMD_WAIT_CYC >> CNT_W) != 0) ||
      ((CLR_WAIT_CYC >> CNT_W) != 0) || ((PWRUP_CYC    >> CNT_W) != 0))
  begin : g_bad_cfg
    $error("lcd_ctrl: timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
`ifdef LCD_INIT_EN
    , PWRUP,
    INIT_NEXT
`endif
  } state_e;

`ifdef LCD_INIT_EN
  localparam state_e          RST_STATE = PWRUP;
  localparam logic [CNT_W-1:0] RST_CNT  = CNT_W'(PWRUP_CYC);
  localparam logic            RST_READY = 1'b0;

  // Power-on init sequence: function set 8-bit/2-line, display on,
  // clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction
`else
  localparam state_e          RST_STATE = IDLE;
  localparam logic [CNT_W-1:0] RST_CNT  = '0;
  localparam logic            RST_READY = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       data_q,  data_d;
  logic             rs_q,    rs_d;
  logic             en_q;
  logic             ready_q;
  logic             on_q;
  logic             last;
  logic             is_clr;

`ifdef LCD_INIT_EN
  logic [1:0]       step_q,  step_d;
  logic             init_q,  init_d;
`endif

  // Phase ends when the counter reaches 1; the <= guards against a stuck 0.
  assign last = (cnt_q <= ONE);

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_clr = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) ||
                            (data_q == 8'h03));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
`ifdef LCD_INIT_EN
    step_d  = step_q;
    init_d  = init_q;
`endif
    case (state_q)
      IDLE: begin
        // ready_o is high exactly in IDLE, so req_i alone means accept.
        if (req_i) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          data_d  = data_i;
          rs_d    = rs_i;
        end
      end
      SETUP: begin
        if (last) begin
          state_d = PULSE;
          cnt_d   = EN_LD;
        end else begin
          cnt_d   = cnt_q - ONE;
        end
      end
      PULSE: begin
        if (last) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d   = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (last) begin
          state_d = WAIT;
          cnt_d   = is_clr ? CLR_LD : CMD_LD;
        end else begin
          cnt_d   = cnt_q - ONE;
        end
      end
      WAIT: begin
        if (last) begin
          cnt_d   = ONE;
`ifdef LCD_INIT_EN
          if (init_q && (step_q != 2'd3)) begin
            state_d = INIT_NEXT;
            step_d  = step_q + 2'd1;
          end else begin
            state_d = IDLE;
            init_d  = 1'b0;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d   = cnt_q - ONE;
        end
      end
`ifdef LCD_INIT_EN
      PWRUP: begin
        if (last) begin
          state_d = INIT_NEXT;
          cnt_d   = ONE;
        end else begin
          cnt_d   = cnt_q - ONE;
        end
      end
      INIT_NEXT: begin
        // Single-cycle load of the next init byte, then the normal bus path.
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        data_d  = init_byte(step_q);
        rs_d    = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = ONE;
      end
    endcase
  end

  // en/ready are registered from the next state so the pins are glitch-free
  // and still change on the same edge as the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= RST_READY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= (state_d == PULSE);
      ready_q <= (state_d == IDLE);
    end
  end

`ifdef LCD_INIT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= '0;
      init_q <= 1'b1;
    end else begin
      step_q <= step_d;
      init_q <= init_d;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_q <= 1'b0;
    end else begin
      on_q <= on_i;
    end
  end

  assign ready_o    = ready_q;
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
//
// Directed self-checking bench for lcd_ctrl. Built without LCD_INIT_EN it
// exercises the software-driven path (CLR_WAIT_CYC shortened to keep the run
// short); built with LCD_INIT_EN it exercises the autonomous init sequence
// with PWRUP_CYC=10, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;

`ifdef LCD_INIT_EN
  localparam int unsigned P_CMD = 5;
  localparam int unsigned P_CLR = 20;
  localparam int unsigned P_PWR = 10;
`else
  localparam int unsigned P_CMD = 2000;
  localparam int unsigned P_CLR = 8000;
  localparam int unsigned P_PWR = 750000;
`endif
  localparam int LIMIT = 9000;
  // Accept-to-ready latency: setup 2 + enable 12 + hold 2 + wait.
  localparam int T_CMD = 16 + P_CMD;
  localparam int T_CLR = 16 + P_CLR;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_i = 1'b0;
  logic       rs_i  = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       on_i  = 1'b0;
  logic       ready_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;

  int vectors = 0;
  int miscompares = 0;

  lcd_ctrl #(
    .SETUP_CYC    (2),
    .EN_CYC       (12),
    .HOLD_CYC     (2),
    .CMD_WAIT_CYC (P_CMD),
    .CLR_WAIT_CYC (P_CLR),
    .PWRUP_CYC    (P_PWR),
    .CNT_W        (20)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .ready_o    (ready_o),
    .rs_i       (rs_i),
    .data_i     (data_i),
    .on_i       (on_i),
    .lcd_data_o (lcd_data_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_en_o   (lcd_en_o),
    .lcd_on_o   (lcd_on_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request (caller is 1ns after an edge with ready_o=1), then
  // observe 1ns after every edge until ready_o returns. t counts edges after
  // the accepting edge E0. busy_at>=0 injects a 1-cycle 0x42 request then.
  task automatic xfer(input logic r, input logic [7:0] d, input int busy_at,
                      output int t_ready, output int t_rise,
                      output int n_high, output int n_pulses,
                      output logic stable);
    int   t;
    logic prev;
    req_i = 1'b1; rs_i = r; data_i = d;
    @(posedge clk_i); #1;
    req_i = 1'b0; rs_i = 1'b0; data_i = 8'h00;
    t = 0; prev = 1'b0; t_ready = -1; t_rise = -1;
    n_high = 0; n_pulses = 0; stable = 1'b1;
    while (t < LIMIT) begin
      if ((lcd_data_o !== d) || (lcd_rs_o !== r)) stable = 1'b0;
      if (lcd_en_o === 1'b1) begin
        n_high++;
        if (!prev) begin
          n_pulses++;
          if (t_rise < 0) t_rise = t;
        end
      end
      prev = lcd_en_o;
      if (ready_o === 1'b1) begin
        t_ready = t;
        break;
      end
      if (t == busy_at) begin
        req_i = 1'b1; rs_i = 1'b1; data_i = 8'h42;
      end else begin
        req_i = 1'b0; rs_i = 1'b0; data_i = 8'h00;
      end
      @(posedge clk_i); #1;
      t++;
    end
    req_i = 1'b0; rs_i = 1'b0; data_i = 8'h00;
  endtask

  initial begin
    int   tr, te, nh, np;
    logic st;
    logic got_en;
`ifdef LCD_INIT_EN
    int         t;
    int         npl;
    logic [7:0] seen_d [4];
    logic       seen_rs [4];
    logic       prev_en;
    logic       ready_seen;
`endif

    // ---------------- reset ----------------
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst_data", 32'(lcd_data_o), 32'h00);
    check("rst_rs",   32'(lcd_rs_o),   32'd0);
    check("rst_rw",   32'(lcd_rw_o),   32'd0);
    check("rst_en",   32'(lcd_en_o),   32'd0);
    check("rst_on",   32'(lcd_on_o),   32'd0);
`ifdef LCD_INIT_EN
    check("rst_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    // Watch the whole init sequence; a request during init must be ignored.
    t = 0; npl = 0; prev_en = 1'b0; ready_seen = 1'b0;
    while (t < 500) begin
      @(posedge clk_i); #1;
      t++;
      req_i  = (t >= 30) && (t < 40);
      rs_i   = 1'b1;
      data_i = 8'h55;
      if ((lcd_en_o === 1'b1) && !prev_en) begin
        if (npl < 4) begin
          seen_d[npl]  = lcd_data_o;
          seen_rs[npl] = lcd_rs_o;
        end
        npl++;
      end
      prev_en = lcd_en_o;
      if (ready_o === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
    end
    req_i = 1'b0; rs_i = 1'b0; data_i = 8'h00;
    check("init_ready_seen", 32'(ready_seen), 32'd1);
    // 10 powerup + (1+16+5)*3 + (1+16+20) = 113 edges after release
    check("init_ready_time", 32'(t), 32'd113);
    check("init_pulses", 32'(npl), 32'd4);
    check("init_byte0", 32'(seen_d[0]), 32'h38);
    check("init_byte1", 32'(seen_d[1]), 32'h0C);
    check("init_byte2", 32'(seen_d[2]), 32'h01);
    check("init_byte3", 32'(seen_d[3]), 32'h06);
    check("init_rs", 32'({seen_rs[0], seen_rs[1], seen_rs[2], seen_rs[3]}),
          32'd0);
    check("init_last_data", 32'(lcd_data_o), 32'h06);

    xfer(1'b1, 8'h41, -1, tr, te, nh, np, st);
    check("post_init_ready", 32'(tr), 32'(T_CMD));
    check("post_init_rise",  32'(te), 32'd2);
    check("post_init_width", 32'(nh), 32'd12);
    check("post_init_stable", 32'(st), 32'd1);
    xfer(1'b0, 8'h01, -1, tr, te, nh, np, st);
    check("post_init_clr", 32'(tr), 32'(T_CLR));
`else
    check("rst_ready", 32'(ready_o), 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_ready", 32'(ready_o), 32'd1);

    // lcd_on_o follows on_i one cycle later
    on_i = 1'b1;
    #1;
    check("on_before_edge", 32'(lcd_on_o), 32'd0);
    @(posedge clk_i); #1;
    check("on_after_edge", 32'(lcd_on_o), 32'd1);

    // data write, default timing
    xfer(1'b1, 8'h41, -1, tr, te, nh, np, st);
    check("wr_ready_time", 32'(tr), 32'd2016);
    check("wr_en_rise",    32'(te), 32'd2);
    check("wr_en_width",   32'(nh), 32'd12);
    check("wr_en_pulses",  32'(np), 32'd1);
    check("wr_stable",     32'(st), 32'd1);

    // clear and home-class commands take the long wait
    xfer(1'b0, 8'h01, -1, tr, te, nh, np, st);
    check("clr01_ready_time", 32'(tr), 32'(T_CLR));
    xfer(1'b0, 8'h03, -1, tr, te, nh, np, st);
    check("home03_ready_time", 32'(tr), 32'(T_CLR));
    // neighbours of the clear range and data bytes take the short wait
    xfer(1'b0, 8'h80, -1, tr, te, nh, np, st);
    check("cmd80_ready_time", 32'(tr), 32'd2016);
    xfer(1'b0, 8'h04, -1, tr, te, nh, np, st);
    check("cmd04_ready_time", 32'(tr), 32'd2016);
    xfer(1'b1, 8'h01, -1, tr, te, nh, np, st);
    check("data01_ready_time", 32'(tr), 32'd2016);
    check("data01_stable", 32'(st), 32'd1);

    // request while busy (during WAIT) is dropped
    xfer(1'b1, 8'h41, 100, tr, te, nh, np, st);
    check("busy_pulses", 32'(np), 32'd1);
    check("busy_stable", 32'(st), 32'd1);
    check("busy_ready_time", 32'(tr), 32'd2016);
    #20;
    check("busy_data_after", 32'(lcd_data_o), 32'h41);

    // reset in the middle of the enable pulse
    req_i = 1'b1; rs_i = 1'b1; data_i = 8'h5A;
    @(posedge clk_i); #1;
    req_i = 1'b0; rs_i = 1'b0; data_i = 8'h00;
    got_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      if (lcd_en_o === 1'b1) begin
        got_en = 1'b1;
        break;
      end
    end
    check("mid_en_seen", 32'(got_en), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_en",    32'(lcd_en_o),   32'd0);
    check("mid_rst_ready", 32'(ready_o),    32'd1);
    check("mid_rst_data",  32'(lcd_data_o), 32'h00);
    check("mid_rst_rs",    32'(lcd_rs_o),   32'd0);
    check("mid_rst_on",    32'(lcd_on_o),   32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_ready", 32'(ready_o), 32'd1);
    xfer(1'b0, 8'h33, -1, tr, te, nh, np, st);
    check("post_rst_ready_time", 32'(tr), 32'd2016);
    check("post_rst_en_rise",    32'(te), 32'd2);
    check("post_rst_en_width",   32'(nh), 32'd12);
    check("post_rst_stable",     32'(st), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware sequencer for the HD44780-compatible 16x2 character LCD on the board. Accepts one byte (command or character) per valid/ready handshake from the LSU's LCD output register path. Generates the bus timing on the LCD pins (setup, enable pulse, hold, execution wait), so software never bit-bangs the enable line. Optionally runs the power-on initialization sequence on its own after reset.

## Interface
Parameters:
- SETUP_CYC, default 2: cycles that RS/data are stable before EN rises (≥1).
- EN_CYC, default 12: cycles EN is held high (≥1).
- HOLD_CYC, default 2: cycles that RS/data are held after EN falls (≥1).
- CMD_WAIT_CYC, default 2000: execution wait for normal commands and characters (≥1).
- CLR_WAIT_CYC, default 82000: execution wait for clear/home commands (≥1).
- PWRUP_CYC, default 750000: power-on delay before init; used only with LCD_INIT_EN.
- CNT_W, default 20: wait-counter width; every *_CYC must be < 2^CNT_W.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid.
- ready_o  out  1  block idle and able to accept.
- rs_i  in  1  register select for request: 0 command, 1 data.
- data_i  in  8  byte for request.
- on_i  in  1  LCD power/backlight enable request.
- lcd_data_o  out  8  LCD data bus.
- lcd_rs_o  out  1  LCD register select.
- lcd_rw_o  out  1  LCD read/write; constant 0 (write only).
- lcd_en_o  out  1  LCD enable strobe.
- lcd_on_o  out  1  LCD power enable.

## Operation
- Handshake: a transfer occurs on a rising edge with req_i=1 and ready_o=1. The block captures rs_i and data_i into lcd_rs_o and lcd_data_o on that edge. req_i while ready_o=0 is ignored (no queue). The requester holds req_i until it is accepted.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT, plus PWRUP and INIT_NEXT under LCD_INIT_EN.
  - IDLE -> SETUP on accept.
  - SETUP -> PULSE after SETUP_CYC.
  - PULSE -> HOLD after EN_CYC.
  - HOLD -> WAIT after HOLD_CYC.
  - WAIT -> IDLE (or INIT_NEXT) after the wait count.
- Wait selection: CLR_WAIT_CYC when the latched rs=0 and data ∈ {0x01, 0x02, 0x03}. CMD_WAIT_CYC for all other requests.
- One down-counter, CNT_W bits wide, is loaded on every state entry; the state advances when it reaches 1. The counter never wraps.
- lcd_en_o=1 only in PULSE.
- lcd_data_o and lcd_rs_o change only on accept (or on init step load). They hold their last value in IDLE.
- lcd_on_o is a registered copy of on_i: 1-cycle latency, independent of the FSM.

## Timing
- Reset values:
  - lcd_data_o=0x00, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_on_o=0.
  - ready_o=1 without LCD_INIT_EN, 0 with it.
- Counting from accepting edge E0:
  - lcd_en_o rises after edge E0+SETUP_CYC.
  - lcd_en_o falls after edge E0+SETUP_CYC+EN_CYC.
  - ready_o rises after edge E0+SETUP_CYC+EN_CYC+HOLD_CYC+WAIT.
  - The earliest next accept is on the edge where ready_o is first sampled 1.
- ready_o falls after edge E0; a back-to-back accept is impossible.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous), including lcd_en_o=0 mid-pulse. The FSM returns to IDLE, or to PWRUP under LCD_INIT_EN.

## Configuration
- LCD_INIT_EN defined:
  - After reset, the FSM waits PWRUP_CYC in PWRUP, with ready_o=0.
  - It then issues, with rs=0 and through the normal SETUP/PULSE/HOLD/WAIT path: 0x38, 0x0C, 0x01 (CLR_WAIT_CYC), 0x06.
  - ready_o rises only after the final WAIT.
- LCD_INIT_EN undefined:
  - No PWRUP/INIT_NEXT states exist and PWRUP_CYC is unused.
  - ready_o=1 from reset; software performs initialization.

## Test plan
- Reset, macro off: after rst_i pulse, all LCD outputs are 0 and ready_o=1. Toggle on_i=1: lcd_on_o=1 one cycle later.
- Data write, defaults: accept rs=1, data=0x41.
  - lcd_data_o=0x41 and lcd_rs_o=1 from E0+1 and stable throughout.
  - lcd_en_o high for exactly 12 cycles starting E0+2.
  - ready_o returns at E0+2016.
- Clear command: accept rs=0, data=0x01. ready_o returns at E0+82016. Repeat with 0x80: ready_o returns at E0+2016.
- Request while busy: 1-cycle req_i pulse with 0x42 during WAIT. Required: no extra EN pulse, and lcd_data_o stays at the previous byte.
- Reset during PULSE: assert rst_i while lcd_en_o=1. lcd_en_o=0 in the same cycle, before the next clock edge. After release, ready_o=1 and a new request executes normally.
- Macro on, PWRUP_CYC=10, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20:
  - Exactly four EN pulses, with lcd_data_o 0x38, 0x0C, 0x01, 0x06 and lcd_rs_o=0.
  - ready_o=0 throughout and 1 only after the fourth wait; req_i asserted during init is ignored.
